// File: rtl/countdown_pkg.sv
// -----------------------------------------------------------------------------
// countdown_pkg
// Shared types and helpers for the countdown timer.
//   state_t             : FSM states (IDLE, RUN, PAUSE, ALARM)
//   bcd_t               : one BCD digit
//   MAX_TENS_MS         : largest tens digit for minutes and seconds
//   MAX_HOUR            : largest hour value
//   preset_valid()      : range check of a BCD hh:mm:ss preset
//   hour_bcd_to_bin()   : two BCD hour digits -> binary 0..23
//   hour_bin_to_bcd()   : binary 0..23 -> two BCD hour digits {tens, ones}
// -----------------------------------------------------------------------------
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam int MAX_TENS_MS = 5;
    localparam int MAX_HOUR    = 23;
    localparam int HOUR_W      = 5;

    // Hour value is formed in 8 bits so that a tens digit up to 15 cannot
    // wrap around and sneak under the 23 limit.
    function automatic logic preset_valid(input logic [1:0][3:0] h,
                                          input logic [1:0][3:0] m,
                                          input logic [1:0][3:0] s);
        logic [7:0] hv;
        hv = 8'(h[1]) * 8'd10 + 8'(h[0]);
        return (h[0] <= 4'd9) && (m[0] <= 4'd9) && (s[0] <= 4'd9) &&
               (m[1] <= 4'(MAX_TENS_MS)) && (s[1] <= 4'(MAX_TENS_MS)) &&
               (hv <= 8'(MAX_HOUR));
    endfunction

    // Only called on presets that already passed preset_valid().
    function automatic logic [HOUR_W-1:0] hour_bcd_to_bin(input logic [1:0][3:0] h);
        return HOUR_W'(h[1]) * HOUR_W'(10) + HOUR_W'(h[0]);
    endfunction

    function automatic logic [7:0] hour_bin_to_bcd(input logic [HOUR_W-1:0] v);
        bcd_t tens;
        bcd_t ones;
        if (v >= HOUR_W'(20)) begin
            tens = 4'd2;
            ones = 4'(v - HOUR_W'(20));
        end else if (v >= HOUR_W'(10)) begin
            tens = 4'd1;
            ones = 4'(v - HOUR_W'(10));
        end else begin
            tens = 4'd0;
            ones = 4'(v);
        end
        return {tens, ones};
    endfunction

endpackage

// File: rtl/countdown_timer_sub_counter.sv
// -----------------------------------------------------------------------------
// sub_counter
// Modulo-N down counter: N-1, ..., 1, 0, N-1, ...
//   clk        : rising-edge clock
//   reset      : synchronous active-high, forces counter to 0
//   en         : count down one step this cycle
//   load       : load load_value this cycle (wins over en)
//   load_value : value taken on load
//   counter    : current count
//   borrow     : en && counter == 0, i.e. this step wraps to N-1; it is the
//                enable for the next more significant stage
// -----------------------------------------------------------------------------
module sub_counter #(
    parameter int N = 10,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] counter,
    output logic         borrow
);

    always_ff @(posedge clk) begin
        if (reset) begin
            counter <= '0;
        end else if (load) begin
            counter <= load_value;
        end else if (en) begin
            if (counter == '0) begin
                counter <= W'(N - 1);
            end else begin
                counter <= counter - W'(1);
            end
        end
    end

    assign borrow = en && (counter == '0);

endmodule

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
// hh:mm:ss BCD countdown timer with preset load, start/pause and alarm.
//
// Control handshake: load, start, pause and ack are single-cycle strobes
// sampled on the rising edge of clk. There is no backpressure; a strobe that
// the current state does not accept is dropped. When several strobes arrive
// together the order is load > ack > start > pause. A load seen outside RUN
// consumes the cycle whether it is accepted or rejected.
//
// Ports
//   clk                  : system clock, rising edge
//   reset                : synchronous, active-high
//   load                 : load preset (accepted in IDLE, PAUSE, ALARM)
//   set_hour/minute/second [1:0][3:0] : BCD preset, [1] = tens, [0] = ones
//   start                : start/resume countdown, or leave ALARM
//   pause                : freeze countdown while running
//   ack                  : leave ALARM
//   hour/minute/second   : BCD remaining time
//   running              : state is RUN
//   done                 : one-cycle pulse on entry to ALARM
//   alarm                : state is ALARM
//   load_err             : one-cycle pulse after a rejected preset
//   state_dbg            : current FSM state
// -----------------------------------------------------------------------------
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [1:0][3:0] set_hour,
    input  logic [1:0][3:0] set_minute,
    input  logic [1:0][3:0] set_second,
    input  logic            start,
    input  logic            pause,
    input  logic            ack,
    output logic [1:0][3:0] hour,
    output logic [1:0][3:0] minute,
    output logic [1:0][3:0] second,
    output logic            running,
    output logic            done,
    output logic            alarm,
    output logic            load_err,
    output state_t          state_dbg
);

    localparam int DIV_W = $clog2(TICK_DIV);

    state_t state_q;
    state_t state_d;

    logic accept_load;
    logic reject_load;
    logic clear_time;
    logic clear_div;
    logic done_d;
    logic done_q;
    logic load_err_q;
    logic preset_ok;

    logic             div_en;
    logic             tick;
    logic [DIV_W-1:0] div_cnt;

    bcd_t              sec_ones;
    bcd_t              sec_tens;
    bcd_t              min_ones;
    bcd_t              min_tens;
    logic [HOUR_W-1:0] hour_bin;
    logic              sec_ones_b;
    logic              sec_tens_b;
    logic              min_ones_b;
    logic              min_tens_b;
    logic              hour_b;

    logic              time_load;
    bcd_t              ld_sec_ones;
    bcd_t              ld_sec_tens;
    bcd_t              ld_min_ones;
    bcd_t              ld_min_tens;
    logic [HOUR_W-1:0] ld_hour;

    logic time_zero;
    logic time_last;

    // The divider value itself and the hour-stage borrow are not needed:
    // the FSM leaves RUN before the hour stage could ever borrow.
    logic unused_sig;
    assign unused_sig = ^{div_cnt, hour_b};

    assign preset_ok = preset_valid(set_hour, set_minute, set_second);

    assign time_zero = (hour_bin == '0) && (min_tens == '0) && (min_ones == '0) &&
                       (sec_tens == '0) && (sec_ones == '0);
    // 00:00:01 -- the next tick lands on zero and must raise the alarm.
    assign time_last = (hour_bin == '0) && (min_tens == '0) && (min_ones == '0) &&
                       (sec_tens == '0) && (sec_ones == 4'd1);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            load_err_q <= reject_load;
        end
    end

    always_comb begin
        state_d     = state_q;
        accept_load = 1'b0;
        reject_load = 1'b0;
        clear_time  = 1'b0;
        clear_div   = 1'b0;
        if (load && (state_q != RUN)) begin
            if (preset_ok) begin
                accept_load = 1'b1;
                clear_div   = 1'b1;
                state_d     = IDLE;
            end else begin
                reject_load = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !time_zero) begin
                        state_d   = RUN;
                        clear_div = 1'b1;
                    end
                end
                RUN: begin
                    // A tick that reaches zero outranks a coincident pause.
                    if (tick && time_last) begin
                        state_d = ALARM;
                    end else if (pause) begin
                        state_d = PAUSE;
                    end
                end
                PAUSE: begin
                    // Divider is held, so the partial second is kept.
                    if (start && !time_zero) begin
                        state_d = RUN;
                    end
                end
                ALARM: begin
                    if (ack || start) begin
                        state_d    = IDLE;
                        clear_time = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        done_d = (state_d == ALARM) && (state_q != ALARM);
    end

    // ------------------------------------------------------------------
    // Tick divider: reload to TICK_DIV-1 so the first tick comes exactly
    // TICK_DIV cycles after the start edge.
    // ------------------------------------------------------------------
    assign div_en = (state_q == RUN);

    sub_counter #(.N(TICK_DIV), .W(DIV_W)) u_div (
        .clk        (clk),
        .reset      (reset),
        .en         (div_en),
        .load       (clear_div),
        .load_value (DIV_W'(TICK_DIV - 1)),
        .counter    (div_cnt),
        .borrow     (tick)
    );

    // ------------------------------------------------------------------
    // Time stages, chained by borrow: each stage steps only when every
    // lower stage is at zero on a tick.
    // ------------------------------------------------------------------
    assign time_load   = accept_load || clear_time;
    assign ld_sec_ones = accept_load ? set_second[0] : '0;
    assign ld_sec_tens = accept_load ? set_second[1] : '0;
    assign ld_min_ones = accept_load ? set_minute[0] : '0;
    assign ld_min_tens = accept_load ? set_minute[1] : '0;
    assign ld_hour     = accept_load ? hour_bcd_to_bin(set_hour) : '0;

    sub_counter #(.N(10), .W(4)) u_sec_ones (
        .clk(clk), .reset(reset), .en(tick), .load(time_load),
        .load_value(ld_sec_ones), .counter(sec_ones), .borrow(sec_ones_b)
    );

    sub_counter #(.N(MAX_TENS_MS + 1), .W(4)) u_sec_tens (
        .clk(clk), .reset(reset), .en(sec_ones_b), .load(time_load),
        .load_value(ld_sec_tens), .counter(sec_tens), .borrow(sec_tens_b)
    );

    sub_counter #(.N(10), .W(4)) u_min_ones (
        .clk(clk), .reset(reset), .en(sec_tens_b), .load(time_load),
        .load_value(ld_min_ones), .counter(min_ones), .borrow(min_ones_b)
    );

    sub_counter #(.N(MAX_TENS_MS + 1), .W(4)) u_min_tens (
        .clk(clk), .reset(reset), .en(min_ones_b), .load(time_load),
        .load_value(ld_min_tens), .counter(min_tens), .borrow(min_tens_b)
    );

    sub_counter #(.N(MAX_HOUR + 1), .W(HOUR_W)) u_hour (
        .clk(clk), .reset(reset), .en(min_tens_b), .load(time_load),
        .load_value(ld_hour), .counter(hour_bin), .borrow(hour_b)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign hour      = hour_bin_to_bcd(hour_bin);
    assign minute    = {min_tens, min_ones};
    assign second    = {sec_tens, sec_ones};
    assign running   = (state_q == RUN);
    assign alarm     = (state_q == ALARM);
    assign done      = done_q;
    assign load_err  = load_err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;
    import countdown_pkg::*;

    localparam int TD = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic            load;
    logic [1:0][3:0] set_hour;
    logic [1:0][3:0] set_minute;
    logic [1:0][3:0] set_second;
    logic            start;
    logic            pause;
    logic            ack;
    logic [1:0][3:0] hour;
    logic [1:0][3:0] minute;
    logic [1:0][3:0] second;
    logic            running;
    logic            done;
    logic            alarm;
    logic            load_err;
    state_t          state_dbg;

    countdown_timer #(.TICK_DIV(TD)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .set_hour   (set_hour),
        .set_minute (set_minute),
        .set_second (set_second),
        .start      (start),
        .pause      (pause),
        .ack        (ack),
        .hour       (hour),
        .minute     (minute),
        .second     (second),
        .running    (running),
        .done       (done),
        .alarm      (alarm),
        .load_err   (load_err),
        .state_dbg  (state_dbg)
    );

    // Observed word: {hh:mm:ss BCD, running, done, alarm, load_err, state}
    localparam int OW = 30;
    logic [OW-1:0] obs;
    assign obs = {hour, minute, second, running, done, alarm, load_err, state_dbg};

    function automatic logic [OW-1:0] pk(input logic [23:0] t, input logic run,
                                         input logic dn, input logic al,
                                         input logic le, input state_t st);
        return {t, run, dn, al, le, st};
    endfunction

    // Seconds remaining -> BCD hhmmss, by plain division.
    function automatic logic [23:0] to_bcd(input int s);
        int h;
        int m;
        int x;
        h = s / 3600;
        m = (s / 60) % 60;
        x = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    // ---------------- scoreboard ----------------
    logic [OW-1:0] exp_q[$];
    string         name_q[$];
    int            n_vec = 0;
    int            n_err = 0;

    always @(posedge clk) begin
        logic [OW-1:0] e;
        string         nm;
        #1;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL %s: got %h (t=%h run=%b done=%b alarm=%b lerr=%b st=%0d) expected %h",
                         nm, obs, obs[29:6], obs[5], obs[4], obs[3], obs[2], obs[1:0], e);
            end
        end
    end

    // ---------------- driver ----------------
    // Called at a falling edge: drive one cycle of inputs, queue the value
    // expected just after the next rising edge, advance to next falling edge.
    task automatic cyc(input logic r, input logic l, input logic s, input logic p,
                       input logic a, input logic [23:0] pre,
                       input logic [OW-1:0] e, input string nm);
        reset      = r;
        load       = l;
        start      = s;
        pause      = p;
        ack        = a;
        set_hour   = pre[23:16];
        set_minute = pre[15:8];
        set_second = pre[7:0];
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
    endtask

    task automatic hold(input int n, input logic [OW-1:0] e, input string nm);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0, e, nm);
    endtask

    task automatic do_load(input logic [23:0] pre, input logic [OW-1:0] e, input string nm);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, pre, e, nm);
    endtask

    task automatic do_start(input logic [OW-1:0] e, input string nm);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0, e, nm);
    endtask

    task automatic do_pause(input logic [OW-1:0] e, input string nm);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0, e, nm);
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic          r;
        logic          l;
        logic          s;
        logic          p;
        logic          a;
        logic [23:0]   pre;
        logic [OW-1:0] e;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic l, input logic s,
                                input logic p, input logic a,
                                input logic [23:0] pre, input logic [OW-1:0] e);
        vec_t v;
        v.r = r; v.l = l; v.s = s; v.p = p; v.a = a; v.pre = pre; v.e = e;
        return v;
    endfunction

    localparam int NV = 15;
    vec_t tbl[NV];

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test ----------------
    initial begin
        logic [OW-1:0] z_idle;
        int            rem;

        z_idle = pk(24'h0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE);

        tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0, z_idle);
        tbl[1]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'h123456, z_idle);
        tbl[2]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0, z_idle);
        tbl[3]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h240000, pk(24'h0, 1'b0, 1'b0, 1'b0, 1'b1, IDLE));
        tbl[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0, z_idle);
        tbl[5]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h006000, pk(24'h0, 1'b0, 1'b0, 1'b0, 1'b1, IDLE));
        tbl[6]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h123456, pk(24'h123456, 1'b0, 1'b0, 1'b0, 1'b0, IDLE));
        tbl[7]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h235959, pk(24'h235959, 1'b0, 1'b0, 1'b0, 1'b0, IDLE));
        tbl[8]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h00000a, pk(24'h235959, 1'b0, 1'b0, 1'b0, 1'b1, IDLE));
        tbl[9]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000060, pk(24'h235959, 1'b0, 1'b0, 1'b0, 1'b1, IDLE));
        tbl[10] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000a00, pk(24'h235959, 1'b0, 1'b0, 1'b0, 1'b1, IDLE));
        tbl[11] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h190000, pk(24'h190000, 1'b0, 1'b0, 1'b0, 1'b0, IDLE));
        tbl[12] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000105, pk(24'h000105, 1'b0, 1'b0, 1'b0, 1'b0, IDLE));
        tbl[13] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0, pk(24'h000105, 1'b0, 1'b0, 1'b0, 1'b0, IDLE));
        tbl[14] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0, pk(24'h000105, 1'b0, 1'b0, 1'b0, 1'b0, IDLE));

        reset = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0; ack = 1'b0;
        set_hour = '0; set_minute = '0; set_second = '0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            cyc(tbl[i].r, tbl[i].l, tbl[i].s, tbl[i].p, tbl[i].a, tbl[i].pre, tbl[i].e,
                $sformatf("table[%0d]", i));
        end

        // 00:01:05 counts to zero: one decrement every TD cycles, alarm at 65 ticks.
        do_start(pk(to_bcd(65), 1'b1, 1'b0, 1'b0, 1'b0, RUN), "cd_start");
        for (int c = 1; c <= 65 * TD + 1; c++) begin
            rem = 65 - c / TD;
            if (rem > 0)
                hold(1, pk(to_bcd(rem), 1'b1, 1'b0, 1'b0, 1'b0, RUN), $sformatf("cd_c%0d", c));
            else if (c == 65 * TD)
                hold(1, pk(24'h0, 1'b0, 1'b1, 1'b1, 1'b0, ALARM), "cd_done");
            else
                hold(1, pk(24'h0, 1'b0, 1'b0, 1'b1, 1'b0, ALARM), "cd_alarm_hold");
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0, z_idle, "alarm_ack");
        do_start(z_idle, "start_zero_after_ack");

        // Full borrow ripple 01:00:00 -> 00:59:59.
        do_load(24'h010000, pk(24'h010000, 1'b0, 1'b0, 1'b0, 1'b0, IDLE), "ripple_load");
        do_start(pk(24'h010000, 1'b1, 1'b0, 1'b0, 1'b0, RUN), "ripple_start");
        hold(TD - 1, pk(24'h010000, 1'b1, 1'b0, 1'b0, 1'b0, RUN), "ripple_wait");
        hold(1, pk(24'h005959, 1'b1, 1'b0, 1'b0, 1'b0, RUN), "ripple_tick");
        do_pause(pk(24'h005959, 1'b0, 1'b0, 1'b0, 1'b0, PAUSE), "ripple_pause");

        // Pause mid-second, resume keeps the partial second.
        do_load(24'h000020, pk(24'h000020, 1'b0, 1'b0, 1'b0, 1'b0, IDLE), "pz_load");
        do_start(pk(24'h000020, 1'b1, 1'b0, 1'b0, 1'b0, RUN), "pz_start");
        hold(1, pk(24'h000020, 1'b1, 1'b0, 1'b0, 1'b0, RUN), "pz_run");
        do_pause(pk(24'h000020, 1'b0, 1'b0, 1'b0, 1'b0, PAUSE), "pz_pause");
        hold(10, pk(24'h000020, 1'b0, 1'b0, 1'b0, 1'b0, PAUSE), "pz_frozen");
        do_start(pk(24'h000020, 1'b1, 1'b0, 1'b0, 1'b0, RUN), "pz_resume");
        hold(1, pk(24'h000020, 1'b1, 1'b0, 1'b0, 1'b0, RUN), "pz_resume_wait");
        hold(1, pk(24'h000019, 1'b1, 1'b0, 1'b0, 1'b0, RUN), "pz_resume_tick");
        hold(TD - 1, pk(24'h000019, 1'b1, 1'b0, 1'b0, 1'b0, RUN), "pz_run2");
        do_pause(pk(24'h000018, 1'b0, 1'b0, 1'b0, 1'b0, PAUSE), "pause_on_tick");
        do_start(pk(24'h000018, 1'b1, 1'b0, 1'b0, 1'b0, RUN), "pz_resume2");
        do_load(24'h000050, pk(24'h000018, 1'b1, 1'b0, 1'b0, 1'b0, RUN), "load_in_run");
        do_load(24'h240000, pk(24'h000018, 1'b1, 1'b0, 1'b0, 1'b0, RUN), "bad_load_in_run");

        // Load from PAUSE, then reset in the middle of RUN.
        do_pause(pk(24'h000018, 1'b0, 1'b0, 1'b0, 1'b0, PAUSE), "pz_pause2");
        do_load(24'h000030, pk(24'h000030, 1'b0, 1'b0, 1'b0, 1'b0, IDLE), "load_from_pause");
        do_start(pk(24'h000030, 1'b1, 1'b0, 1'b0, 1'b0, RUN), "rst_start");
        hold(1, pk(24'h000030, 1'b1, 1'b0, 1'b0, 1'b0, RUN), "rst_run");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0, z_idle, "reset_mid_run");
        hold(TD + 1, z_idle, "after_reset");

        // ALARM left by start; then load outranks ack in ALARM.
        do_load(24'h000001, pk(24'h000001, 1'b0, 1'b0, 1'b0, 1'b0, IDLE), "al_load");
        do_start(pk(24'h000001, 1'b1, 1'b0, 1'b0, 1'b0, RUN), "al_start");
        hold(TD - 1, pk(24'h000001, 1'b1, 1'b0, 1'b0, 1'b0, RUN), "al_wait");
        hold(1, pk(24'h0, 1'b0, 1'b1, 1'b1, 1'b0, ALARM), "al_done");
        hold(1, pk(24'h0, 1'b0, 1'b0, 1'b1, 1'b0, ALARM), "al_hold");
        do_start(z_idle, "alarm_start");
        do_load(24'h000001, pk(24'h000001, 1'b0, 1'b0, 1'b0, 1'b0, IDLE), "al2_load");
        do_start(pk(24'h000001, 1'b1, 1'b0, 1'b0, 1'b0, RUN), "al2_start");
        hold(TD - 1, pk(24'h000001, 1'b1, 1'b0, 1'b0, 1'b0, RUN), "al2_wait");
        hold(1, pk(24'h0, 1'b0, 1'b1, 1'b1, 1'b0, ALARM), "al2_done");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 24'h000007,
            pk(24'h000007, 1'b0, 1'b0, 1'b0, 1'b0, IDLE), "load_over_ack");
        hold(2, pk(24'h000007, 1'b0, 1'b0, 1'b0, 1'b0, IDLE), "final_idle");

        // Let the checker drain the last entry.
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
